// File: rtl/int2fp_seq.sv
// Sequential integer-to-float converter: a leading-zero normalise loop followed by
// one round-to-nearest-even step, with a valid/ready handshake on each side.
module int2fp_seq #(
    parameter int W       = 16,
    parameter int EXP_LEN = 8,
    parameter int MAN     = 7
) (
    input  logic                     clock,
    input  logic                     nreset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    input  logic                     in_signed,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_LEN+MAN:0]     out_data,
    output logic                     out_inexact,
    output logic [1:0]               dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready is high only in IDLE, out_valid only in DONE, and out_data holds until consumed.

    localparam int LZW  = $clog2(W);
    localparam int BIAS = 2 ** (EXP_LEN - 1) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [W-1:0]   mag;
    logic [LZW-1:0] lz;
    logic           sign;

    logic           in_neg;
    logic [W-1:0]   in_mag;

    logic [MAN-1:0] man_trunc;
    logic           guard;
    logic           sticky;
    logic           round_up;
    logic [W-1:0]   low_bits;
    logic [MAN:0]   man_sum;
    logic [EXP_LEN:0] exp_base;
    logic [EXP_LEN:0] exp_final;

    // Negating -2**(W-1) wraps to 2**(W-1), which is the correct unsigned magnitude.
    assign in_neg = in_signed & in_data[W-1];
    assign in_mag = in_neg ? -in_data : in_data;

    // Shifting out everything down to the guard bit leaves only the sticky field.
    assign man_trunc = mag[W-2 -: MAN];
    assign guard     = mag[W-2-MAN];
    assign low_bits  = mag << (MAN + 2);
    assign sticky    = |low_bits;
    assign round_up  = guard & (sticky | man_trunc[0]);
    assign man_sum   = {1'b0, man_trunc} + {{MAN{1'b0}}, round_up};
    assign exp_base  = (EXP_LEN+1)'(BIAS + W - 1) - {{(EXP_LEN+1-LZW){1'b0}}, lz};
    assign exp_final = exp_base + {{EXP_LEN{1'b0}}, man_sum[MAN]};

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (in_mag == '0) ? DONE : NORM;
            end
            NORM: begin
                if (mag[W-1]) state_next = ROUND;
            end
            ROUND: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            mag         <= '0;
            lz          <= '0;
            sign        <= 1'b0;
            out_data    <= '0;
            out_inexact <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign <= in_neg;
                        mag  <= in_mag;
                        lz   <= '0;
                        if (in_mag == '0) begin
                            out_data    <= '0;
                            out_inexact <= 1'b0;
                        end
                    end
                end
                NORM: begin
                    if (!mag[W-1]) begin
                        mag <= mag << 1;
                        lz  <= lz + LZW'(1);
                    end
                end
                ROUND: begin
                    out_data    <= {sign, exp_final[EXP_LEN-1:0], man_sum[MAN-1:0]};
                    out_inexact <= guard | sticky;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int2fp_seq.sv
// Directed bench for int2fp_seq at W=16: a vector table of hand-computed floats and
// latencies, plus backpressure, busy-input and mid-conversion reset sequences.
module tb_int2fp_seq;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_inexact;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] data;
        logic        sgn;
        logic [15:0] exp_data;
        logic        exp_inx;
        int          exp_lat;
    } vec_t;

    vec_t vecs[17];

    int2fp_seq #(.W(16), .EXP_LEN(8), .MAN(7)) dut (
        .clock       (clock),
        .nreset      (nreset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_signed   (in_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_inexact (out_inexact),
        .dbg_state   (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Drives one conversion, measures edges from accept to out_valid, then optionally
    // stalls the output for 'hold' cycles before consuming it.
    task automatic convert(input vec_t v, input int hold, input bit noisy);
        int lat;
        logic [15:0] want;
        @(negedge clock);
        in_data   = v.data;
        in_signed = v.sgn;
        in_valid  = 1'b1;
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        exp_q.push_back(v.exp_data);
        @(posedge clock);
        #1;
        in_valid = noisy;
        in_data  = noisy ? 16'($urandom_range(0, 65535)) : 16'h0;
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!out_valid && lat < 100);
        in_valid = 1'b0;
        want = exp_q.pop_front();
        chk($sformatf("latency_%0h", v.data), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("data_%0h", v.data), 32'(out_data), 32'(want));
        chk($sformatf("inexact_%0h", v.data), 32'(out_inexact), 32'(v.exp_inx));
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(want));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk("idle_after_handshake", 32'(in_ready), 32'd1);
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("data_hold_after", 32'(out_data), 32'(want));
    endtask

    initial begin
        vec_t v;
        int seen;
        vecs[0]  = '{16'h0001, 1'b1, 16'h3F80, 1'b0, 17};
        vecs[1]  = '{16'hFFFF, 1'b1, 16'hBF80, 1'b0, 17};
        vecs[2]  = '{16'd300,  1'b1, 16'h4396, 1'b0, 9};
        vecs[3]  = '{16'h0000, 1'b1, 16'h0000, 1'b0, 1};
        vecs[4]  = '{16'h8000, 1'b1, 16'hC700, 1'b0, 2};
        vecs[5]  = '{16'd257,  1'b0, 16'h4380, 1'b1, 9};
        vecs[6]  = '{16'd259,  1'b0, 16'h4382, 1'b1, 9};
        vecs[7]  = '{16'd255,  1'b0, 16'h437F, 1'b0, 10};
        vecs[8]  = '{16'd511,  1'b0, 16'h4400, 1'b1, 9};
        vecs[9]  = '{16'hFFFF, 1'b0, 16'h4780, 1'b1, 2};
        vecs[10] = '{16'h0003, 1'b0, 16'h4040, 1'b0, 16};
        vecs[11] = '{16'h7FFF, 1'b1, 16'h4700, 1'b1, 3};
        vecs[12] = '{16'h8000, 1'b0, 16'h4700, 1'b0, 2};
        vecs[13] = '{16'd258,  1'b0, 16'h4381, 1'b0, 9};
        vecs[14] = '{16'd385,  1'b0, 16'h43C0, 1'b1, 9};
        vecs[15] = '{16'd641,  1'b0, 16'h4420, 1'b1, 8};
        vecs[16] = '{16'd771,  1'b0, 16'h4441, 1'b1, 8};

        #2;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_inexact", 32'(out_inexact), 32'd0);
        chk("reset_state", 32'(dbg_state), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        nreset = 1'b1;

        for (int i = 0; i < 17; i++) convert(vecs[i], 0, 1'b0);

        // Backpressure with busy in_valid noise during NORM and DONE.
        convert(vecs[2], 5, 1'b1);
        convert(vecs[0], 2, 1'b1);

        // Reset pulse in the middle of normalising input 1.
        @(negedge clock);
        in_data   = 16'h0001;
        in_signed = 1'b1;
        in_valid  = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk("mid_conv_state", 32'(dbg_state), 32'd1);
        nreset = 1'b0;
        #1;
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        chk("midreset_out_data", 32'(out_data), 32'd0);
        @(negedge clock);
        nreset = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock);
            #1;
            if (out_valid) seen++;
        end
        chk("abandoned_no_valid", 32'(seen), 32'd0);
        v = '{16'd300, 1'b1, 16'h4396, 1'b0, 9};
        convert(v, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
